mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of all data buses.
REQ-002 Parameter AW, default 32, address width of all address buses.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  AW  fetch address.
- if_kill  in  1  abandon the current or pending fetch (branch/jump redirect).
- if_rdata  out  DW  fetched word, valid when if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_be  in  4  store byte enables.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data, valid when dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory port request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion; may arrive any cycle mem_req=1, including the first.
- stallF  out  1  freeze fetch/decode stages.
- stallM  out  1  freeze memory stage and older stages.

Function
REQ-004 The FSM SHALL have states IDLE, BUSY_I and BUSY_D.
REQ-005 In IDLE, a grant SHALL be issued in the same cycle as the request:
- dm_req=1: grant data.
- else if_req=1 and if_kill=0: grant fetch.
REQ-006 When both dm_req and if_req are pending, data SHALL win.
REQ-007 On grant, the block SHALL register the granted command (addr, we, be, wdata; fetch forces we=0, be=4'hF) into mem_* and go to BUSY_D/BUSY_I next cycle.
REQ-008 mem_req SHALL be 1 exactly in BUSY states; mem_* fields SHALL stay constant throughout BUSY.
REQ-009 In BUSY with mem_ready=1, the block SHALL capture mem_rdata into the owner's rdata register, pulse that owner's ack the next cycle, and return to IDLE.
REQ-010 Minimum latency: request at cycle 0, mem_req cycles 1..k, ack at cycle k+1 (k>=1).
REQ-011 In the ack cycle the acked requester's req SHALL be ignored for granting; only the other requester may be granted, giving back-to-back service without re-issuing a consumed request.
REQ-012 For a store, dm_rdata SHALL hold its previous value; dm_ack SHALL still pulse.
REQ-013 if_kill=1 in any cycle of a fetch, from grant cycle through the mem_ready cycle, SHALL complete the memory transaction but suppress if_ack and leave if_rdata unchanged.
REQ-014 if_kill=1 in IDLE SHALL block a fetch grant that cycle.
REQ-015 if_kill SHALL not affect data transactions.
REQ-016 stallM SHALL be dm_req & ~dm_ack (combinational).
REQ-017 stallF SHALL be (if_req & ~if_ack & ~if_kill) | stallM (combinational).
REQ-018 mem_ready=1 outside BUSY SHALL be ignored.
REQ-019 No new grant SHALL occur while in a BUSY state.

Reset
REQ-020 rst=0 SHALL immediately and asynchronously force state=IDLE and all registered outputs to 0 (mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, if_ack, dm_rdata, dm_ack).
REQ-021 A reset in mid-transaction SHALL abandon the transaction with no ack after release.
REQ-022 The first grant SHALL be possible in the first clock edge after rst returns to 1.

Verification
REQ-023 Single load: dm_req=1, dm_we=0, dm_addr=0x100, mem_ready=1 in cycle 1 with mem_rdata=0xDEADBEEF -> mem_req high only in cycle 1; dm_ack=1 and dm_rdata=0xDEADBEEF in cycle 2; stallM=1 in cycles 0-1.
REQ-024 Simultaneous requests: if_req (0x0040) and dm_req store (0x200, wdata 0x12345678, be 4'b0011) at cycle 0, mem_ready fixed at 1 -> store on port in cycle 1 with mem_be=0011; dm_ack cycle 2 and fetch grant cycle 2; fetch on port cycle 3; if_ack cycle 4.
REQ-025 Wait states: fetch with mem_ready low for 3 cycles -> mem_addr/mem_req constant for 4 cycles; single if_ack; stallF high throughout.
REQ-026 Kill: fetch granted, if_kill=1 in cycle 1, mem_ready in cycle 2 -> no if_ack, if_rdata unchanged, state IDLE in cycle 3.
REQ-027 Reset mid-operation: rst=0 during BUSY_D -> mem_req=0 asynchronously; after release, no dm_ack until a new request completes.
REQ-028 Stray ready: mem_ready=1 in IDLE with no requests -> no ack, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access, data first
module mem_port_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stallF,
    output logic          stallM
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state_q, state_d;
    logic          kill_q, kill_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          dm_go, if_go;

    // a request being acked this cycle is already consumed and must not be granted again
    assign dm_go = dm_req & ~dm_ack_q;
    assign if_go = if_req & ~if_ack_q & ~if_kill;

    assign stallM    = dm_req & ~dm_ack_q;
    assign stallF    = (if_req & ~if_ack_q & ~if_kill) | stallM;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;

    // next-state: grant in IDLE, wait for mem_ready in BUSY, track fetch kills
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_go) begin
                    state_d     = BUSY_D;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_go) begin
                    state_d    = BUSY_I;
                    kill_d     = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 4'hF;
                    mem_addr_d = if_addr;
                end
            end
            BUSY_I: begin
                kill_d = kill_q | if_kill;
                if (mem_ready) begin
                    state_d    = IDLE;
                    if_ack_d   = ~kill_d;
                    if_rdata_d = kill_d ? if_rdata_q : mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = mem_we_q ? dm_rdata_q : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_req_d = state_d != IDLE;
    end

    // state and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: cycle-by-cycle directed vectors plus reset corner sequences
module tb_mem_port_arbiter;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_ack, dm_req, dm_we, dm_ack;
    logic        mem_req, mem_we, mem_ready, stallF, stallM;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  dm_be, mem_be;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        ifr, ifk;
        logic [31:0] ifa;
        logic        dmr, we;
        logic [3:0]  be;
        logic [31:0] dma, wd;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd;
        logic        e_ifack, e_dmack, e_sf, e_sm;
        logic [31:0] e_ifrd, e_dmrd;
    } vec_t;

    vec_t vq[$];

    mem_port_arbiter #(.DW(32), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stallF(stallF), .stallM(stallM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_req = v.ifr; if_kill = v.ifk; if_addr = v.ifa;
        dm_req = v.dmr; dm_we = v.we; dm_be = v.be; dm_addr = v.dma; dm_wdata = v.wd;
        mem_ready = v.rdy; mem_rdata = v.rd;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_kill = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0;
        dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        // load 0x100, then stray ready in IDLE
        vq.push_back('{N,N,'h0,  Y,N,4'h0,'h100,'h0, N,'h0,        N,N,4'h0,'h100-'h100,'h0, N,N,Y,Y,'h0,'h0});
        vq.push_back('{N,N,'h0,  Y,N,4'h0,'h100,'h0, Y,'hDEADBEEF, Y,N,4'h0,'h100,'h0, N,N,Y,Y,'h0,'h0});
        vq.push_back('{N,N,'h0,  Y,N,4'h0,'h100,'h0, N,'h0,        N,N,4'h0,'h100,'h0, N,Y,N,N,'h0,'hDEADBEEF});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0,   Y,'h55,       N,N,4'h0,'h100,'h0, N,N,N,N,'h0,'hDEADBEEF});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0,   N,'h0,        N,N,4'h0,'h100,'h0, N,N,N,N,'h0,'hDEADBEEF});
        // simultaneous fetch 0x40 and store 0x200, ready held high
        vq.push_back('{Y,N,'h40, Y,Y,4'h3,'h200,'h12345678, Y,'h0, N,N,4'h0,'h100,'h0,        N,N,Y,Y,'h0,'hDEADBEEF});
        vq.push_back('{Y,N,'h40, Y,Y,4'h3,'h200,'h12345678, Y,'h0, Y,Y,4'h3,'h200,'h12345678, N,N,Y,Y,'h0,'hDEADBEEF});
        vq.push_back('{Y,N,'h40, Y,Y,4'h3,'h200,'h12345678, Y,'h0, N,Y,4'h3,'h200,'h12345678, N,Y,Y,N,'h0,'hDEADBEEF});
        vq.push_back('{Y,N,'h40, N,N,4'h0,'h0,'h0, Y,'hCAFEF00D,   Y,N,4'hF,'h40,'h12345678,  N,N,Y,N,'h0,'hDEADBEEF});
        vq.push_back('{Y,N,'h40, N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'h40,'h12345678,  Y,N,N,N,'hCAFEF00D,'hDEADBEEF});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'h40,'h12345678,  N,N,N,N,'hCAFEF00D,'hDEADBEEF});
        // fetch 0x80 with three wait states
        vq.push_back('{Y,N,'h80, N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'h40,'h12345678,  N,N,Y,N,'hCAFEF00D,'hDEADBEEF});
        vq.push_back('{Y,N,'h80, N,N,4'h0,'h0,'h0, N,'h0,          Y,N,4'hF,'h80,'h12345678,  N,N,Y,N,'hCAFEF00D,'hDEADBEEF});
        vq.push_back('{Y,N,'h80, N,N,4'h0,'h0,'h0, N,'h0,          Y,N,4'hF,'h80,'h12345678,  N,N,Y,N,'hCAFEF00D,'hDEADBEEF});
        vq.push_back('{Y,N,'h80, N,N,4'h0,'h0,'h0, N,'h0,          Y,N,4'hF,'h80,'h12345678,  N,N,Y,N,'hCAFEF00D,'hDEADBEEF});
        vq.push_back('{Y,N,'h80, N,N,4'h0,'h0,'h0, Y,'h11112222,   Y,N,4'hF,'h80,'h12345678,  N,N,Y,N,'hCAFEF00D,'hDEADBEEF});
        vq.push_back('{Y,N,'h80, N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'h80,'h12345678,  Y,N,N,N,'h11112222,'hDEADBEEF});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'h80,'h12345678,  N,N,N,N,'h11112222,'hDEADBEEF});
        // fetch 0xC0 killed while busy, then kill blocking an IDLE grant
        vq.push_back('{Y,N,'hC0, N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'h80,'h12345678,  N,N,Y,N,'h11112222,'hDEADBEEF});
        vq.push_back('{Y,Y,'hC0, N,N,4'h0,'h0,'h0, N,'h0,          Y,N,4'hF,'hC0,'h12345678,  N,N,N,N,'h11112222,'hDEADBEEF});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0, Y,'h99999999,   Y,N,4'hF,'hC0,'h12345678,  N,N,N,N,'h11112222,'hDEADBEEF});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'hC0,'h12345678,  N,N,N,N,'h11112222,'hDEADBEEF});
        vq.push_back('{Y,Y,'h100,N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'hC0,'h12345678,  N,N,N,N,'h11112222,'hDEADBEEF});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0, N,'h0,          N,N,4'hF,'hC0,'h12345678,  N,N,N,N,'h11112222,'hDEADBEEF});
        // load 0x300 with kill held high throughout
        vq.push_back('{N,Y,'h0,  Y,N,4'h0,'h300,'h0, N,'h0,        N,N,4'hF,'hC0,'h12345678,  N,N,Y,Y,'h11112222,'hDEADBEEF});
        vq.push_back('{N,Y,'h0,  Y,N,4'h0,'h300,'h0, Y,'hABCD0123, Y,N,4'h0,'h300,'h0,        N,N,Y,Y,'h11112222,'hDEADBEEF});
        vq.push_back('{N,Y,'h0,  Y,N,4'h0,'h300,'h0, N,'h0,        N,N,4'h0,'h300,'h0,        N,Y,N,N,'h11112222,'hABCD0123});
        vq.push_back('{N,N,'h0,  N,N,4'h0,'h0,'h0,   N,'h0,        N,N,4'h0,'h300,'h0,        N,N,N,N,'h11112222,'hABCD0123});

        repeat (2) @(negedge clk);
        #1;
        chk("rst mem_req", {31'b0, mem_req}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst acks", {30'b0, if_ack, dm_ack}, 0);
        chk("rst rdata", if_rdata | dm_rdata, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, vq[i].e_req});
            chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vq[i].e_we});
            chk($sformatf("v%0d mem_be", i), {28'b0, mem_be}, {28'b0, vq[i].e_be});
            chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].e_wd);
            chk($sformatf("v%0d if_ack", i), {31'b0, if_ack}, {31'b0, vq[i].e_ifack});
            chk($sformatf("v%0d dm_ack", i), {31'b0, dm_ack}, {31'b0, vq[i].e_dmack});
            chk($sformatf("v%0d stallF", i), {31'b0, stallF}, {31'b0, vq[i].e_sf});
            chk($sformatf("v%0d stallM", i), {31'b0, stallM}, {31'b0, vq[i].e_sm});
            chk($sformatf("v%0d if_rdata", i), if_rdata, vq[i].e_ifrd);
            chk($sformatf("v%0d dm_rdata", i), dm_rdata, vq[i].e_dmrd);
        end

        // reset asserted between edges while a store is on the port
        @(negedge clk);
        idle_inputs();
        dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 'h400; dm_wdata = 'h77;
        @(negedge clk);
        #1;
        chk("busy mem_req", {31'b0, mem_req}, 1);
        chk("busy mem_addr", mem_addr, 'h400);
        #2;
        rst = 1'b0;
        #1;
        chk("async mem_req", {31'b0, mem_req}, 0);
        chk("async mem_addr", mem_addr, 0);
        chk("async mem_wdata", mem_wdata, 0);
        chk("async mem_we_be", {27'b0, mem_we, mem_be}, 0);
        chk("async dm_rdata", dm_rdata, 0);
        dm_req = 0;
        @(negedge clk);
        mem_ready = 1;
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 0;
        dm_req = 1; dm_we = 0; dm_be = 0; dm_addr = 'h500;
        #1;
        chk("rel dm_ack", {31'b0, dm_ack}, 0);
        chk("rel mem_req", {31'b0, mem_req}, 0);
        chk("rel stallM", {31'b0, stallM}, 1);
        @(negedge clk);
        mem_ready = 1; mem_rdata = 'h600D;
        #1;
        chk("first grant mem_req", {31'b0, mem_req}, 1);
        chk("first grant addr", mem_addr, 'h500);
        chk("first grant no ack", {31'b0, dm_ack}, 0);
        @(negedge clk);
        mem_ready = 0;
        #1;
        chk("post-rst dm_ack", {31'b0, dm_ack}, 1);
        chk("post-rst dm_rdata", dm_rdata, 'h600D);
        @(negedge clk);
        dm_req = 0;
        #1;
        chk("post-rst ack pulse", {31'b0, dm_ack}, 0);
        chk("post-rst idle", {31'b0, mem_req}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
